mips_cpu_delay_slot_seq: RTL

- Sequences the program counter around MIPS branch/jump delay slots for the multicycle CPU.
- Latches a resolved branch or jump target and lets exactly one delay-slot instruction retire; on that retire, the PC is redirected to the target.
- Detects the halt condition: a redirect to HALT_ADDR takes effect after its delay slot retires.
- Sits between the branch/jump resolution logic and the PC register, replacing ad-hoc delay-slot timing with a clocked FSM.

---
 rtl/mips_cpu_pkg.sv | 14 +
 rtl/mips_cpu_delay_slot_seq.sv | 117 +++++++++++
 2 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS multicycle CPU PC sequencing logic.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        SEQ    = 2'd0,
        DELAY  = 2'd1,
        HALTED = 2'd2
    } seq_state_t;

    localparam logic [31:0] MIPS_RESET_VECTOR = 32'hBFC00000;
    localparam logic [31:0] MIPS_HALT_ADDR    = 32'h00000000;
    localparam logic [31:0] INSTR_BYTES       = 32'd4;

endpackage

// File: rtl/mips_cpu_delay_slot_seq.sv
// PC sequencer that retires exactly one delay-slot instruction before redirecting to a latched target.
// Optional macro MIPS_CPU_DELAY_SLOT_CHECK_EN flags branches/jumps found inside a delay slot.
module mips_cpu_delay_slot_seq
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = MIPS_RESET_VECTOR,
    parameter logic [31:0] HALT_ADDR    = MIPS_HALT_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_done,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc_out,
    output logic        delay_active,
    output logic        redirect,
    output logic        active,
    output logic        err_slot_branch
);

    seq_state_t  state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] tgt_reg, tgt_next;
    logic        redirect_reg, redirect_next;
    logic        delay_active_reg;
    logic        active_reg;

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        tgt_next      = tgt_reg;
        redirect_next = 1'b0;
        case (state_reg)
            SEQ: begin
                if (instr_done) begin
                    pc_next = pc_reg + INSTR_BYTES;
                    // Jump outranks a simultaneous taken branch.
                    if (jump) begin
                        tgt_next   = jump_target;
                        state_next = DELAY;
                    end else if (branch_taken) begin
                        tgt_next   = branch_target;
                        state_next = DELAY;
                    end
                end
            end
            DELAY: begin
                // Requests from the slot instruction itself are dropped; the latched target wins.
                if (instr_done) begin
                    pc_next       = tgt_reg;
                    redirect_next = 1'b1;
                    state_next    = (tgt_reg == HALT_ADDR) ? HALTED : SEQ;
                end
            end
            HALTED: begin
            end
            default: begin
                state_next = SEQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= SEQ;
            pc_reg           <= RESET_VECTOR;
            tgt_reg          <= 32'h0;
            redirect_reg     <= 1'b0;
            delay_active_reg <= 1'b0;
            active_reg       <= 1'b1;
        end else begin
            state_reg        <= state_next;
            pc_reg           <= pc_next;
            tgt_reg          <= tgt_next;
            redirect_reg     <= redirect_next;
            delay_active_reg <= (state_next == DELAY);
            active_reg       <= (state_next != HALTED);
        end
    end

    assign pc_out       = pc_reg;
    assign delay_active = delay_active_reg;
    assign redirect     = redirect_reg;
    assign active       = active_reg;

`ifdef MIPS_CPU_DELAY_SLOT_CHECK_EN
    logic slot_branch;
    logic err_pulse_reg;
    logic err_sticky_reg;

    assign slot_branch = (state_reg == DELAY) && instr_done && (jump || branch_taken);

    always_ff @(posedge clk) begin
        if (reset) begin
            err_pulse_reg  <= 1'b0;
            err_sticky_reg <= 1'b0;
        end else begin
            err_pulse_reg  <= slot_branch;
            err_sticky_reg <= err_sticky_reg | slot_branch;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!slot_branch)
                else $error("branch or jump inside delay slot at pc %08h", pc_reg);
        end
    end

    assign err_slot_branch = err_pulse_reg;
`else
    assign err_slot_branch = 1'b0;
`endif

endmodule
